// File: rtl/servo_pwm_gen_pkg.sv
// Shared types and default constants for the servo pulse generator.
// The frame period constant is the same one used by the upstream
// microsecond frame counter.
package servo_pkg;

    typedef enum logic {
        DISARMED = 1'b0,
        ARMED    = 1'b1
    } servo_state_t;

    typedef logic [15:0] us_t;

    localparam us_t SERVO_MIN_US    = 16'd1000;
    localparam us_t SERVO_MAX_US    = 16'd2000;
    localparam us_t SERVO_CENTER_US = 16'd1500;
    localparam us_t SERVO_STEP_US   = 16'd100;
    localparam us_t SERVO_PERIOD_US = 16'd20000;

endpackage

// File: rtl/servo_pwm_gen_slew_step.sv
// Combinational slew step: next active width moves from i_active toward
// i_target by at most STEP_US per call.
module servo_slew_step
    import servo_pkg::*;
#(
    parameter us_t STEP_US = SERVO_STEP_US
) (
    input  us_t i_active,
    input  us_t i_target,
    output us_t o_next
);

    us_t w_diff;

    // Magnitude of the error is taken only after ordering the operands,
    // so the subtraction can never wrap.
    always_comb begin
        w_diff = '0;
        o_next = i_target;
        if (i_target >= i_active) begin
            w_diff = i_target - i_active;
            if (w_diff > STEP_US) begin
                o_next = i_active + STEP_US;
            end
        end else begin
            w_diff = i_active - i_target;
            if (w_diff > STEP_US) begin
                o_next = i_active - STEP_US;
            end
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: accepts clamped width commands, applies them at
// frame wraps of the upstream microsecond counter and drives a registered
// PWM pin. Define SERVO_SLEW_EN to limit the width change per frame.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter us_t MIN_US    = SERVO_MIN_US,
    parameter us_t MAX_US    = SERVO_MAX_US,
    parameter us_t CENTER_US = SERVO_CENTER_US,
    parameter us_t STEP_US   = SERVO_STEP_US
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] counter,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_pulse_us,
    output logic        cmd_ready,
    output logic        cmd_clamped,
    output logic        frame_start,
    output logic        busy,
    output logic        pwm
);

    servo_state_t r_state;
    us_t          r_prev_counter;
    us_t          r_active;
    us_t          r_target;
    logic         r_pending;
    logic         r_clamped;
    logic         r_frame_start;
    logic         r_pwm;

    servo_state_t w_state_nxt;
    us_t          w_clamp_val;
    logic         w_clamp_hit;
    logic         w_frame_start;
    logic         w_accept;
    us_t          w_step_next;
    us_t          w_active_nxt;

    assign w_frame_start = (counter == 16'd0) && (r_prev_counter != 16'd0);
    assign w_accept      = cmd_valid && !r_pending;

`ifdef SERVO_SLEW_EN
    servo_slew_step #(
        .STEP_US (STEP_US)
    ) u_slew (
        .i_active (r_active),
        .i_target (r_target),
        .o_next   (w_step_next)
    );
`else
    logic w_unused_step;
    assign w_unused_step = ^STEP_US;
    assign w_step_next   = r_target;
`endif

    // Clamp the requested width into the legal range and compute next state/width.
    always_comb begin
        w_clamp_val = cmd_pulse_us;
        w_clamp_hit = 1'b0;
        if (cmd_pulse_us < MIN_US) begin
            w_clamp_val = MIN_US;
            w_clamp_hit = 1'b1;
        end else if (cmd_pulse_us > MAX_US) begin
            w_clamp_val = MAX_US;
            w_clamp_hit = 1'b1;
        end
        w_state_nxt  = r_state;
        if ((r_state == DISARMED) && w_frame_start) begin
            w_state_nxt = ARMED;
        end
        w_active_nxt = w_frame_start ? w_step_next : r_active;
    end

    // Arm FSM, command latch and registered outputs; the width update uses
    // the target held before any same-cycle accept, so a command landing on
    // the wrap edge stays pending for one more frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= DISARMED;
            r_prev_counter <= '0;
            r_active       <= CENTER_US;
            r_target       <= CENTER_US;
            r_pending      <= 1'b0;
            r_clamped      <= 1'b0;
            r_frame_start  <= 1'b0;
            r_pwm          <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_prev_counter <= counter;
            r_active       <= w_active_nxt;
            r_frame_start  <= w_frame_start;
            r_clamped      <= w_accept && w_clamp_hit;
            r_pwm          <= (w_state_nxt == ARMED) && (counter < w_active_nxt);
            if (w_accept) begin
                r_target  <= w_clamp_val;
                r_pending <= 1'b1;
            end else if (w_frame_start) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign cmd_ready   = !r_pending;
    assign cmd_clamped = r_clamped;
    assign frame_start = r_frame_start;
    assign busy        = r_pending || (r_active != r_target);
    assign pwm         = r_pwm;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen. Counter model wraps at 2100 and
// advances every clock to keep frames short while still exceeding MAX_US.
module tb_servo_pwm_gen;

    localparam int PERIOD = 2100;
`ifdef SERVO_SLEW_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] counter;
    logic        cmd_valid;
    logic [15:0] cmd_pulse_us;
    logic        cmd_ready;
    logic        cmd_clamped;
    logic        frame_start;
    logic        busy;
    logic        pwm;

    int total = 0;
    int bad   = 0;
    int spurious = 0;
    int n_fs = 0;
    int exp_w[$];
    int exp_c[$];

    servo_pwm_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .counter      (counter),
        .cmd_valid    (cmd_valid),
        .cmd_pulse_us (cmd_pulse_us),
        .cmd_ready    (cmd_ready),
        .cmd_clamped  (cmd_clamped),
        .frame_start  (frame_start),
        .busy         (busy),
        .pwm          (pwm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running upstream frame counter.
    initial begin
        counter = '0;
        forever begin
            @(posedge clk);
            #1;
            counter = (counter == 16'(PERIOD - 1)) ? 16'd0 : counter + 16'd1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Width monitor: each completed pwm pulse is checked against the queue.
    initial begin
        int  hi_cnt;
        bit  pwm_prev;
        hi_cnt   = 0;
        pwm_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hi_cnt   = 0;
                pwm_prev = 1'b0;
            end else begin
                if (pwm) begin
                    hi_cnt++;
                end else if (pwm_prev) begin
                    if (exp_w.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL width_unexpected: got %0d expected none", hi_cnt);
                    end else begin
                        chk("width", hi_cnt, exp_w.pop_front());
                    end
                    hi_cnt = 0;
                end
                pwm_prev = pwm;
            end
        end
    end

    // Clamp / frame_start monitor.
    initial begin
        bit chk_next;
        bit fs_prev;
        chk_next = 1'b0;
        fs_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_next) begin
                if (exp_c.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL clamp_unexpected: got %0d expected none", cmd_clamped);
                end else begin
                    chk("cmd_clamped", int'(cmd_clamped), exp_c.pop_front());
                end
            end else if (cmd_clamped) begin
                spurious++;
            end
            if (frame_start && fs_prev) spurious++;
            fs_prev = frame_start;
            if (frame_start) n_fs++;
            chk_next = rst_n && cmd_valid && cmd_ready;
        end
    end

    task automatic wait_fs(output bit pwm_seen);
        pwm_seen = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (frame_start) return;
            if (pwm) pwm_seen = 1'b1;
        end
        total++;
        bad++;
        $display("FAIL frame_start_timeout: got none expected pulse");
    endtask

    task automatic send(input int val, input int clamp_exp);
        bit ok;
        ok = 1'b0;
        exp_c.push_back(clamp_exp);
        @(posedge clk);
        #2;
        cmd_valid    = 1'b1;
        cmd_pulse_us = 16'(val);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1");
        end
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
    endtask

    initial begin
        bit seen;
        int n0;
        bit found;
        rst_n        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_pulse_us = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_cmd_clamped", int'(cmd_clamped), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pwm", int'(pwm), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // F1: arm at first wrap, centre width
        exp_w.push_back(1500);
        wait_fs(seen);
        chk("pwm_low_before_wrap", int'(seen), 0);
        chk("f1_busy", int'(busy), 0);
        chk("f1_pwm_high", int'(pwm), 1);

        // Command 1800
        exp_w.push_back(SLEW ? 1600 : 1800);
        exp_w.push_back(SLEW ? 1700 : 1800);
        exp_w.push_back(1800);
        send(1800, 0);
        @(negedge clk);
        chk("ready_after_accept", int'(cmd_ready), 0);
        chk("busy_after_accept", int'(busy), 1);
        wait_fs(seen);
        chk("f2_ready_back", int'(cmd_ready), 1);
        wait_fs(seen);
        chk("f3_busy", int'(busy), SLEW ? 1 : 0);
        wait_fs(seen);
        chk("f4_busy", int'(busy), 0);

        // Command 2500 -> clamped to 2000
        exp_w.push_back(SLEW ? 1900 : 2000);
        send(2500, 1);
        wait_fs(seen);

        // Back-to-back 1200 then 1900
        exp_w.push_back(SLEW ? 1800 : 1200);
        send(1200, 0);
        n0 = n_fs;
        @(negedge clk);
        chk("b2b_ready_low", int'(cmd_ready), 0);
        exp_w.push_back(1900);
        send(1900, 0);
        chk("b2b_second_after_fs", n_fs, n0 + 1);
        wait_fs(seen);
        chk("f7_busy", int'(busy), 0);

        // Command landing on the wrap edge: change appears one frame later
        exp_w.push_back(1900);
        exp_w.push_back(SLEW ? 1800 : 1300);
        found = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk);
            #2;
            if (counter == 16'd0) begin
                found = 1'b1;
                break;
            end
        end
        chk("wrap_found", int'(found), 1);
        exp_c.push_back(0);
        cmd_valid    = 1'b1;
        cmd_pulse_us = 16'd1300;
        @(posedge clk);
        #2;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("fs_accept_frame_start", int'(frame_start), 1);
        chk("fs_accept_ready", int'(cmd_ready), 0);
        wait_fs(seen);
        chk("f9_busy", int'(busy), SLEW ? 1 : 0);

        // Reset mid-pulse in F10
        wait_fs(seen);
        repeat (200) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async_pwm", int'(pwm), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ready", int'(cmd_ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        exp_w.push_back(1500);
        wait_fs(seen);
        chk("pwm_low_after_reset", int'(seen), 0);

        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (exp_w.size() == 0) break;
        end
        chk("width_queue_empty", exp_w.size(), 0);
        chk("clamp_queue_empty", exp_c.size(), 0);
        chk("spurious_pulses", spurious, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
